// File: rtl/scan_counter_display_pkg.sv
// Shared constants for the scan counter display: digit width, blank pattern,
// active-low hex glyph table and the radix-dependent digit maximum.
package scan_counter_display_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order gfedcba; entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [DIGIT_W-1:0] digit_max(input bit radix_bcd);
    return radix_bcd ? 4'd9 : 4'hF;
  endfunction

endpackage

// File: rtl/scan_counter_display_seg7_decode.sv
// Combinational 4-bit digit to active-low 7-segment pattern, with blanking.
module seg7_decode
  import scan_counter_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  input  logic               blank,
  output logic [6:0]         seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : GLYPHS[value];
  end

endmodule

// File: rtl/scan_counter_display.sv
// Multi-digit BCD/hex up/down counter with ripple carry, load, wrap pulse,
// and a multiplexed common-anode 7-segment driver with leading-zero blanking.
module scan_counter_display
  import scan_counter_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 100000,
  parameter int RADIX_BCD  = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          up,
  input  logic                          en,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count_o,
  output logic                          wrap_o,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg
);

  localparam int TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]      SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [DIGIT_W-1:0] DMAX      = digit_max(RADIX_BCD != 0);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] count_q, count_nxt, load_sat;
  logic [NUM_DIGITS-1:0]              blank;
  logic                               carry_out;
  logic [TW-1:0]                      tick_cnt;
  logic                               tick;
  logic [SW-1:0]                      scan_cnt;
  logic [IW-1:0]                      scan_idx;
  logic [6:0]                         seg_dec;

  assign tick    = en && (tick_cnt == TICK_LAST);
  assign count_o = count_q;

  // Per-digit load saturation: BCD digits above 9 clamp to 9.
  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      logic [DIGIT_W-1:0] lv;
      assign lv          = load_val[i*DIGIT_W +: DIGIT_W];
      assign load_sat[i] = ((RADIX_BCD != 0) && (lv > 4'd9)) ? 4'd9 : lv;
    end
  endgenerate

  // Ripple carry/borrow resolved combinationally across all digits.
  always_comb begin
    logic c;
    logic at_end;
    count_nxt = count_q;
    c         = 1'b1;
    at_end    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      at_end = up ? (count_q[i] >= DMAX) : (count_q[i] == '0);
      if (c) begin
        if (up) count_nxt[i] = at_end ? '0   : count_q[i] + 4'd1;
        else    count_nxt[i] = at_end ? DMAX : count_q[i] - 4'd1;
      end
      c = c & at_end;
    end
    carry_out = c;
  end

  // A digit is blank when it and every higher digit are zero; digit 0 never blanks.
  always_comb begin
    logic nz;
    blank = '0;
    nz    = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz       = nz | (count_q[i] != '0);
      blank[i] = (BLANK_LZ != 0) && (i != 0) && !nz;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      tick_cnt <= '0;
      wrap_o   <= 1'b0;
    end else begin
      wrap_o <= 1'b0;
      if (load) begin
        count_q  <= load_sat;
        tick_cnt <= '0;
      end else if (en) begin
        if (tick) begin
          tick_cnt <= '0;
          count_q  <= count_nxt;
          wrap_o   <= carry_out;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

  seg7_decode u_dec (
    .value (count_q[scan_idx]),
    .blank (blank[scan_idx]),
    .seg   (seg_dec)
  );

  // an and seg share one register stage so they always switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an       <= '1;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
      an  <= ~(NUM_DIGITS'(1) << scan_idx);
      seg <= seg_dec;
    end
  end

endmodule

// File: tb/tb_scan_counter_display.sv
// Directed bench: BCD instance, hex instance and a TICK_DIV=5 instance share stimulus.
module tb_scan_counter_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        up = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;

  logic [15:0] cnt0, cnt1, cnt2;
  logic        wrap0, wrap1, wrap2;
  logic [3:0]  an0, an1, an2;
  logic [6:0]  seg0, seg1, seg2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scan_counter_display #(.NUM_DIGITS(4), .TICK_DIV(1), .SCAN_DIV(2), .RADIX_BCD(1), .BLANK_LZ(1)) d_bcd (
    .clk(clk), .rst_n(rst_n), .up(up), .en(en), .load(load), .load_val(load_val),
    .count_o(cnt0), .wrap_o(wrap0), .an(an0), .seg(seg0));

  scan_counter_display #(.NUM_DIGITS(4), .TICK_DIV(1), .SCAN_DIV(2), .RADIX_BCD(0), .BLANK_LZ(1)) d_hex (
    .clk(clk), .rst_n(rst_n), .up(up), .en(en), .load(load), .load_val(load_val),
    .count_o(cnt1), .wrap_o(wrap1), .an(an1), .seg(seg1));

  scan_counter_display #(.NUM_DIGITS(4), .TICK_DIV(5), .SCAN_DIV(2), .RADIX_BCD(1), .BLANK_LZ(1)) d_div (
    .clk(clk), .rst_n(rst_n), .up(up), .en(en), .load(load), .load_val(load_val),
    .count_o(cnt2), .wrap_o(wrap2), .an(an2), .seg(seg2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v; en = 1'b0;
    step();
    load = 1'b0;
  endtask

  logic [3:0] exp_an [8] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
  logic [6:0] exp_sg [8] = '{7'h24, 7'h24, 7'h19, 7'h19, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  initial begin
    logic [3:0] prev;
    logic       found;

    // Reset
    #2 rst_n = 1'b0;
    #2;
    check("rst_count", cnt0, 16'h0000);
    check("rst_an",    an0,  4'hF);
    check("rst_seg",   seg0, 7'h7F);
    check("rst_wrap",  wrap0, 1'b0);
    step(); step();
    rst_n = 1'b1;

    // BCD up ripple
    do_load(16'h0999);
    check("load_0999", cnt0, 16'h0999);
    en = 1'b1; up = 1'b1;
    step();
    check("bcd_up_ripple", cnt0, 16'h1000);
    check("bcd_up_nowrap", wrap0, 1'b0);

    // BCD up wrap
    do_load(16'h9999);
    en = 1'b1;
    step();
    check("bcd_up_wrap_cnt", cnt0, 16'h0000);
    check("bcd_up_wrap_pulse", wrap0, 1'b1);
    en = 1'b0;
    step();
    check("bcd_up_wrap_one_cycle", wrap0, 1'b0);

    // BCD down borrow and wrap
    do_load(16'h1000);
    en = 1'b1; up = 1'b0;
    step();
    check("bcd_dn_borrow", cnt0, 16'h0999);
    do_load(16'h0000);
    en = 1'b1;
    step();
    check("bcd_dn_wrap_cnt", cnt0, 16'h9999);
    check("bcd_dn_wrap_pulse", wrap0, 1'b1);
    en = 1'b0;
    step();
    check("bcd_dn_wrap_one_cycle", wrap0, 1'b0);

    // BCD load saturation; hex instance keeps the raw value
    do_load(16'h00AF);
    check("bcd_load_sat", cnt0, 16'h0099);
    check("hex_load_raw", cnt1, 16'h00AF);

    // Hex mode
    up = 1'b1;
    do_load(16'h00FF);
    en = 1'b1;
    step();
    check("hex_up_ripple", cnt1, 16'h0100);
    do_load(16'hFFFF);
    en = 1'b1;
    step();
    check("hex_up_wrap_cnt", cnt1, 16'h0000);
    check("hex_up_wrap_pulse", wrap1, 1'b1);
    do_load(16'h1234);
    repeat (10) step();
    check("hex_en_hold", cnt1, 16'h1234);

    // Scan and blanking with 0042
    do_load(16'h0042);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      prev = an0;
      step();
      if (an0 == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    check("scan_sync", found, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("scan_an_%0d", k), an0, exp_an[k]);
      check($sformatf("scan_seg_%0d", k), seg0, exp_sg[k]);
      step();
    end

    // Load beats a pending tick and a wrap condition
    do_load(16'h9998);
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h9999;
    step();
    check("prio_load_cnt", cnt0, 16'h9999);
    check("prio_load_nowrap", wrap0, 1'b0);
    load = 1'b0; en = 1'b0;

    // Prescale TICK_DIV=5
    do_load(16'h0000);
    en = 1'b1; up = 1'b1;
    repeat (4) step();
    check("div5_before", cnt2, 16'h0000);
    step();
    check("div5_first", cnt2, 16'h0001);
    repeat (4) step();
    check("div5_hold", cnt2, 16'h0001);
    step();
    check("div5_second", cnt2, 16'h0002);

    // Reset mid-count, then resume from zero
    do_load(16'h0041);
    en = 1'b1;
    step();
    #3 rst_n = 1'b0;
    #1;
    check("midrst_count", cnt0, 16'h0000);
    check("midrst_an",    an0,  4'hF);
    check("midrst_seg",   seg0, 7'h7F);
    check("midrst_wrap",  wrap0, 1'b0);
    rst_n = 1'b1;
    step();
    check("resume_count", cnt0, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
